// File: rtl/imm_extend_arbiter_pkg.sv
// Shared definitions for the immediate sign-extension arbiter: default
// widths, requester-ID width, output FSM encoding and the round-robin pick.
package imm_extend_arbiter_pkg;

    localparam int IN_W_DEF  = 7;
    localparam int OUT_W_DEF = 20;
    localparam int ID_W      = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Winner for a non-zero request vector: a lone requester always wins,
    // otherwise the requester named by the round-robin pointer wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [1:0] req,
                                                input logic [ID_W-1:0] prio);
        logic [ID_W-1:0] w;
        w = prio;
        if (req == 2'b01) begin
            w = 1'b0;
        end else if (req == 2'b10) begin
            w = 1'b1;
        end
        return w;
    endfunction

endpackage

// File: rtl/imm_extend_arbiter_if.sv
// Request / result bundle between the two requesters, the consumer and the
// arbiter. The arbiter takes the slave side.
interface imm_extend_arbiter_if
    import imm_extend_arbiter_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);

    logic [1:0]       req;
    logic [IN_W-1:0]  imm0;
    logic [IN_W-1:0]  imm1;
    logic [1:0]       grant;
    logic             out_valid;
    logic [ID_W-1:0]  out_id;
    logic [OUT_W-1:0] out_data;
    logic             out_ready;

    modport master (
        output req, imm0, imm1, out_ready,
        input  grant, out_valid, out_id, out_data
    );

    modport slave (
        input  req, imm0, imm1, out_ready,
        output grant, out_valid, out_id, out_data
    );

endinterface

// File: rtl/imm_extend_arbiter_sext.sv
// Shared sign-extension unit: replicates the immediate's top bit into the
// upper OUT_W-IN_W bits. Purely combinational.
module SevenTwentySignExtend #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 20
) (
    input  logic [IN_W-1:0]  imm_in,
    output logic [OUT_W-1:0] imm_out
);

    assign imm_out = {{(OUT_W - IN_W){imm_in[IN_W-1]}}, imm_in};

endmodule

// File: rtl/imm_extend_arbiter.sv
// Round-robin arbiter sharing one sign-extension unit between two
// requesters; the winner's extended immediate and ID are held in an output
// register under a valid/ready handshake.
module imm_extend_arbiter
    import imm_extend_arbiter_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input logic                clk,
    input logic                rst_n,
    imm_extend_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  prio_q,  prio_d;
    logic [ID_W-1:0]  id_q,    id_d;
    logic [OUT_W-1:0] data_q,  data_d;

    logic             accept;
    logic [ID_W-1:0]  winner;
    logic [IN_W-1:0]  imm_sel;
    logic [OUT_W-1:0] imm_ext;

    // Accept decision, winner selection, request mux and grant.
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        accept  = rst_n && (|bus.req) && (state_q == ST_EMPTY || bus.out_ready);
        winner  = rr_pick(bus.req, prio_q);
        imm_sel = (winner == 1'b1) ? bus.imm1 : bus.imm0;
        bus.grant = 2'b00;
        if (accept) begin
            bus.grant = (winner == 1'b1) ? 2'b10 : 2'b01;
        end
    end

    SevenTwentySignExtend #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_sext (
        .imm_in  (imm_sel),
        .imm_out (imm_ext)
    );

    // Next-state: load on accept (also covers consume-and-reload with no
    // bubble), drain to EMPTY when the consumer takes the result, else hold.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        data_d  = data_q;
        if (accept) begin
            state_d = ST_FULL;
            prio_d  = ~winner;
            id_d    = winner;
            data_d  = imm_ext;
        end else if (state_q == ST_FULL && bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // State, pointer and output register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            prio_q  <= '0;
            id_q    <= '0;
            // NOTE: the data register is reset too because its post-reset value is visible on out_data.
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            data_q  <= data_d;
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_id    = id_q;
    assign bus.out_data  = data_q;

endmodule

// File: tb/tb_imm_extend_arbiter.sv
// Directed bench for imm_extend_arbiter: reset, single request, contention,
// backpressure, no-bubble handoff and reset with a pending result.
module tb_imm_extend_arbiter;

    localparam int IN_W  = 7;
    localparam int OUT_W = 20;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    imm_extend_arbiter_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    imm_extend_arbiter #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational grant settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic id, input logic [19:0] d);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, "_id"},    32'(bus.out_id),    32'(id));
        check({tag, "_data"},  32'(bus.out_data),  32'(d));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req       = 2'b11;
        bus.imm0      = 7'b0101010;
        bus.imm1      = 7'b1100110;
        bus.out_ready = 1'b0;

        // Reset with both requests high: no grant, cleared output.
        tick();
        tick();
        settle();
        check("rst_grant", 32'(bus.grant), 32'h0);
        check_out("rst", 1'b0, 1'b0, 20'h00000);

        // Contention right after reset: 0,1,0 alternation.
        rst_n         = 1'b1;
        bus.req       = 2'b11;
        bus.imm0      = 7'b1000000;
        bus.imm1      = 7'b1111111;
        bus.out_ready = 1'b1;
        settle();
        check("rr_grant0", 32'(bus.grant), 32'h1);
        tick();
        check_out("rr_out0", 1'b1, 1'b0, 20'hFFFC0);
        check("rr_grant1", 32'(bus.grant), 32'h2);
        tick();
        check_out("rr_out1", 1'b1, 1'b1, 20'hFFFFF);
        check("rr_grant2", 32'(bus.grant), 32'h1);
        tick();
        check_out("rr_out2", 1'b1, 1'b0, 20'hFFFC0);

        // Drain with no request: EMPTY, data/id hold.
        bus.req = 2'b00;
        settle();
        check("drain_grant", 32'(bus.grant), 32'h0);
        tick();
        check_out("drain", 1'b0, 1'b0, 20'hFFFC0);

        // Single request from 0 while pointer favours 1.
        bus.req  = 2'b01;
        bus.imm0 = 7'b0000001;
        settle();
        check("single_grant", 32'(bus.grant), 32'h1);
        tick();
        check_out("single", 1'b1, 1'b0, 20'h00001);

        // Requester 1 granted, then backpressure with req[0] pending.
        bus.req  = 2'b10;
        bus.imm1 = 7'b0011111;
        settle();
        check("bp_load_grant", 32'(bus.grant), 32'h2);
        tick();
        check_out("bp_load", 1'b1, 1'b1, 20'h0001F);
        bus.req       = 2'b01;
        bus.imm0      = 7'b0000011;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("bp_hold_grant%0d", i), 32'(bus.grant), 32'h0);
            check($sformatf("bp_hold_data%0d", i), 32'(bus.out_data), 32'h0001F);
            tick();
        end
        check_out("bp_after", 1'b1, 1'b1, 20'h0001F);
        bus.out_ready = 1'b1;
        settle();
        check("bp_release_grant", 32'(bus.grant), 32'h1);
        tick();
        check_out("bp_release", 1'b1, 1'b0, 20'h00003);

        // No-bubble handoff to requester 1.
        bus.req  = 2'b10;
        bus.imm1 = 7'b1010101;
        settle();
        check("handoff_grant", 32'(bus.grant), 32'h2);
        tick();
        check_out("handoff", 1'b1, 1'b1, 20'hFFFD5);

        // Load requester 0 so the pointer points at 1 before reset.
        bus.req  = 2'b01;
        bus.imm0 = 7'b1111110;
        tick();
        check_out("pre_rst", 1'b1, 1'b0, 20'hFFFFE);

        // Reset with a pending result and requests high: dropped, no grant.
        bus.req       = 2'b11;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        settle();
        check("midrst_grant", 32'(bus.grant), 32'h0);
        tick();
        check_out("midrst", 1'b0, 1'b0, 20'h00000);

        // After reset, requester 0 wins first.
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        bus.imm0      = 7'b0111111;
        bus.imm1      = 7'b1000001;
        settle();
        check("post_rst_grant", 32'(bus.grant), 32'h1);
        tick();
        check_out("post_rst", 1'b1, 1'b0, 20'h0003F);
        check("post_rst_grant2", 32'(bus.grant), 32'h2);
        tick();
        check_out("post_rst2", 1'b1, 1'b1, 20'hFFFC1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
